// File: rtl/lock_event_tx.sv
// Lock FSM state-change reporter: each accepted change is sent to a UART as a 4-byte ASCII message.
// Latency: first byte appears 2 cycles after the change; one pending slot, newer events overwrite it.
module lock_event_tx #(
  parameter int TIMEOUT = 16
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       txready,
  output logic [7:0] txdata,
  output logic       txclk,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] PULSE  = 2'd2;
  localparam logic [1:0] WAITLO = 2'd3;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [3:0]    prev_state;
  logic          evt;
  logic          consume;
  logic          slot_vld;
  logic [3:0]    slot_code;
  logic [1:0]    fsm;
  logic [1:0]    fsm_nxt;
  logic [3:0]    msg_code;
  logic [3:0]    msg_nxt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nxt;

  function automatic logic [7:0] msg_byte(input logic [3:0] code, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h0A;
    case (i)
      2'd0: begin
        if (code <= 4'd7)       b = 8'h4C;
        else if (code == 4'd8)  b = 8'h49;
        else if (code == 4'd9)  b = 8'h4F;
        else                    b = 8'h41;
      end
      2'd1: begin
        if (code <= 4'd7)       b = 8'h30 + {4'h0, code};
        else if (code == 4'd8)  b = 8'h4E;
        else if (code == 4'd9)  b = 8'h4B;
        else                    b = 8'h21;
      end
      2'd2:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign evt     = (state != prev_state) && (state <= 4'd10);
  assign consume = (fsm == IDLE) && slot_vld;
  assign busy    = (fsm != IDLE);

  always_comb begin
    fsm_nxt  = fsm;
    msg_nxt  = msg_code;
    idx_nxt  = idx;
    tcnt_nxt = tcnt;
    case (fsm)
      IDLE: begin
        if (slot_vld) begin
          msg_nxt = slot_code;
          idx_nxt = 2'd0;
          fsm_nxt = SEND;
        end
      end
      SEND: begin
        if (txready) fsm_nxt = PULSE;
      end
      PULSE: begin
        tcnt_nxt = '0;
        fsm_nxt  = WAITLO;
      end
      default: begin
        // Leave on the UART taking the byte, or give up after TIMEOUT cycles.
        if (!txready || tcnt == TLAST) begin
          if (idx == 2'd3) begin
            fsm_nxt = IDLE;
          end else begin
            idx_nxt = idx + 2'd1;
            fsm_nxt = SEND;
          end
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      prev_state <= 4'd8;
      slot_vld   <= 1'b0;
      slot_code  <= 4'd0;
      drop_cnt   <= 4'd0;
      fsm        <= IDLE;
      msg_code   <= 4'd0;
      idx        <= 2'd0;
      tcnt       <= '0;
      txdata     <= 8'h00;
      txclk      <= 1'b0;
    end else begin
      prev_state <= state;
      // A same-cycle consume frees the slot, so the incoming event is not a loss.
      if (evt) begin
        slot_vld  <= 1'b1;
        slot_code <= state;
        if (slot_vld && !consume && drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
      end else if (consume) begin
        slot_vld <= 1'b0;
      end
      fsm      <= fsm_nxt;
      msg_code <= msg_nxt;
      idx      <= idx_nxt;
      tcnt     <= tcnt_nxt;
      txdata   <= (fsm_nxt == IDLE) ? 8'h00 : msg_byte(msg_nxt, idx_nxt);
      txclk    <= (fsm_nxt == PULSE);
    end
  end

endmodule

// File: tb/tb_lock_event_tx.sv
// Bench for lock_event_tx: vector table, corner-case sequences, and a randomized run checked
// against a message-level model (ordering, coalescing, drop accounting).
module tb_lock_event_tx;

  localparam int TO = 6;

  logic       hz100;
  logic       reset;
  logic [3:0] state;
  logic       txready;
  logic [7:0] txdata;
  logic       txclk;
  logic       busy;
  logic [3:0] drop_cnt;

  lock_event_tx #(.TIMEOUT(TO)) dut (
    .hz100(hz100), .reset(reset), .state(state), .txready(txready),
    .txdata(txdata), .txclk(txclk), .busy(busy), .drop_cnt(drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 1;       // 0 random, 1 stuck high, 2 one-cycle low after each strobe
  bit mon_en = 0;
  logic [7:0] rx_q[$];
  int pulse_cyc[$];

  typedef struct {
    logic [3:0]  code;
    logic        has_msg;
    logic [31:0] msg;
  } vec_t;
  vec_t tbl[10];

  initial begin
    hz100 = 0;
    forever #5 hz100 = ~hz100;
  end

  initial forever begin
    @(posedge hz100);
    cyc++;
  end

  initial begin
    bit last;
    txready = 1;
    last = 0;
    forever begin
      @(posedge hz100);
      #1;
      case (rdy_mode)
        0:       txready = ($urandom % 3) != 0;
        1:       txready = 1'b1;
        default: txready = !last;
      endcase
      last = (txclk === 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Byte-level monitor: strobe width and idle data value are checked on every cycle.
  initial begin
    bit prev_clk;
    prev_clk = 0;
    forever begin
      @(negedge hz100);
      if (mon_en) begin
        if (txclk === 1'b1) begin
          rx_q.push_back(txdata);
          pulse_cyc.push_back(cyc);
          chk("txclk_single_cycle", {31'd0, prev_clk}, 32'd0);
        end
        if (busy === 1'b0) chk("txdata_zero_idle", {24'd0, txdata}, 32'd0);
        prev_clk = (txclk === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_msg(input int c);
    logic [7:0] b0, b1;
    if (c <= 7) begin
      b0 = "L";
      b1 = 8'(8'h30 + c);
    end else if (c == 8) begin
      b0 = "I"; b1 = "N";
    end else if (c == 9) begin
      b0 = "O"; b1 = "K";
    end else begin
      b0 = "A"; b1 = "!";
    end
    return {b0, b1, 8'h0D, 8'h0A};
  endfunction

  function automatic logic [31:0] rx_word(input int base);
    return {rx_q[base], rx_q[base+1], rx_q[base+2], rx_q[base+3]};
  endfunction

  task automatic drive(input logic [3:0] v);
    @(posedge hz100);
    #1 state = v;
  endtask

  task automatic do_reset();
    state = 4'd8;
    reset = 1;
    repeat (2) @(posedge hz100);
    #1 reset = 0;
  endtask

  task automatic wait_idle(input string nm);
    int low;
    bit done;
    low = 0;
    done = 0;
    repeat (3) @(posedge hz100);
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge hz100);
      low = busy ? 0 : low + 1;
      if (low >= 3) done = 1;
    end
    if (!done) chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    int ev_q[$];
    int msgs[$];
    int bprev;
    logic [3:0] v;

    tbl[0] = '{4'd0,  1'b1, 32'h4C300D0A};
    tbl[1] = '{4'd7,  1'b1, 32'h4C370D0A};
    tbl[2] = '{4'd8,  1'b1, 32'h494E0D0A};
    tbl[3] = '{4'd9,  1'b1, 32'h4F4B0D0A};
    tbl[4] = '{4'd10, 1'b1, 32'h41210D0A};
    tbl[5] = '{4'd12, 1'b0, 32'h0};
    tbl[6] = '{4'd3,  1'b1, 32'h4C330D0A};
    tbl[7] = '{4'd3,  1'b0, 32'h0};
    tbl[8] = '{4'd15, 1'b0, 32'h0};
    tbl[9] = '{4'd5,  1'b1, 32'h4C350D0A};

    state = 4'd8;
    reset = 1;
    do_reset();
    @(negedge hz100);
    chk("rst_txdata", {24'd0, txdata}, 32'd0);
    chk("rst_txclk", {31'd0, txclk}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", {28'd0, drop_cnt}, 32'd0);
    mon_en = 1;
    repeat (6) @(negedge hz100);
    chk("init_hold_no_busy", {31'd0, busy}, 32'd0);
    chk("init_hold_no_bytes", rx_q.size(), 32'd0);

    // Vector table, one state change at a time.
    rdy_mode = 2;
    for (int k = 0; k < 10; k++) begin
      rx_q.delete();
      drive(tbl[k].code);
      wait_idle($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_count", k), rx_q.size(), tbl[k].has_msg ? 32'd4 : 32'd0);
      if (tbl[k].has_msg && rx_q.size() == 4) chk($sformatf("tbl%0d_msg", k), rx_word(0), tbl[k].msg);
      chk($sformatf("tbl%0d_drop", k), {28'd0, drop_cnt}, 32'd0);
    end

    // Coalescing: L1 overwritten while L0 in flight.
    do_reset();
    rdy_mode = 2;
    rx_q.delete();
    pulse_cyc.delete();
    drive(4'd0);
    drive(4'd1);
    drive(4'd2);
    wait_idle("coal");
    chk("coal_count", rx_q.size(), 32'd8);
    if (rx_q.size() == 8) begin
      chk("coal_msg0", rx_word(0), 32'h4C300D0A);
      chk("coal_msg1", rx_word(4), 32'h4C320D0A);
      chk("coal_b2b_gap", pulse_cyc[4] - pulse_cyc[3], 32'd4);
    end
    chk("coal_drop", {28'd0, drop_cnt}, 32'd1);

    // Stuck ready: every byte leaves WAITLO by timeout.
    do_reset();
    rdy_mode = 1;
    rx_q.delete();
    pulse_cyc.delete();
    drive(4'd9);
    wait_idle("stuck");
    chk("stuck_count", rx_q.size(), 32'd4);
    if (rx_q.size() == 4) begin
      chk("stuck_msg", rx_word(0), 32'h4F4B0D0A);
      for (int k = 1; k < 4; k++)
        chk($sformatf("stuck_gap%0d", k), pulse_cyc[k] - pulse_cyc[k-1], TO + 2);
    end

    // Unused code in between.
    do_reset();
    rdy_mode = 2;
    rx_q.delete();
    drive(4'd12);
    drive(4'd10);
    wait_idle("unused");
    chk("unused_count", rx_q.size(), 32'd4);
    if (rx_q.size() == 4) chk("unused_msg", rx_word(0), 32'h41210D0A);

    // Saturation: 22 overwrites during a long message.
    do_reset();
    rdy_mode = 1;
    rx_q.delete();
    drive(4'd0);
    drive(4'd1);
    for (int i = 0; i < 10; i++) drive(4'((i + 2) % 8));
    @(posedge hz100);
    #1 chk("sat_drop10", {28'd0, drop_cnt}, 32'd10);
    for (int i = 10; i < 22; i++) drive(4'((i + 2) % 8));
    @(posedge hz100);
    #1 chk("sat_drop_mid", {28'd0, drop_cnt}, 32'd15);
    wait_idle("sat");
    chk("sat_drop_final", {28'd0, drop_cnt}, 32'd15);
    chk("sat_count", rx_q.size(), 32'd8);
    if (rx_q.size() == 8) chk("sat_last_msg", rx_word(4), 32'h4C370D0A);

    // Reset while the second ALARM byte is being strobed.
    do_reset();
    rdy_mode = 2;
    rx_q.delete();
    drive(4'd10);
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 2; i++) begin
      @(negedge hz100);
      if (txclk === 1'b1) cnt++;
    end
    chk("rstmid_reached", cnt, 32'd2);
    reset = 1;
    state = 4'd8;
    @(posedge hz100);
    #1;
    chk("rstmid_txclk", {31'd0, txclk}, 32'd0);
    chk("rstmid_txdata", {24'd0, txdata}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    @(posedge hz100);
    #1 reset = 0;
    repeat (60) @(posedge hz100);
    chk("rstmid_bytes", rx_q.size(), 32'd2);

    // Randomized run against a message-level model.
    do_reset();
    rdy_mode = 0;
    rx_q.delete();
    bprev = 8;
    for (int i = 0; i < 3000; i++) begin
      @(posedge hz100);
      #1;
      v = ($urandom % 40 == 0) ? 4'($urandom % 16) : state;
      state = v;
      if (int'(v) != bprev && v <= 4'd10) ev_q.push_back(int'(v));
      bprev = int'(v);
    end
    wait_idle("rnd");
    chk("rnd_bytes_mod4", rx_q.size() % 4, 32'd0);
    for (int b = 0; b + 3 < rx_q.size(); b += 4) begin
      int dec;
      dec = -1;
      for (int c = 0; c <= 10; c++) if (ref_msg(c) == rx_word(b)) dec = c;
      chk($sformatf("rnd_msg%0d_valid", b / 4), {31'd0, dec >= 0}, 32'd1);
      msgs.push_back(dec);
    end
    begin
      int j;
      bit ok;
      j = 0;
      ok = 1;
      foreach (msgs[m]) begin
        while (j < ev_q.size() && ev_q[j] != msgs[m]) j++;
        if (j >= ev_q.size()) ok = 0;
        else j++;
      end
      chk("rnd_subsequence", {31'd0, ok}, 32'd1);
    end
    if (ev_q.size() > 0 && msgs.size() > 0) chk("rnd_last_sent", msgs[msgs.size()-1], ev_q[ev_q.size()-1]);
    chk("rnd_drop", {28'd0, drop_cnt},
        ((ev_q.size() - msgs.size()) > 15) ? 32'd15 : 32'(ev_q.size() - msgs.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_event_tx.md
LOCK_EVENT_TX -- requirements
Module: lock_event_tx

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 16, the maximum number of cycles it waits for txready to fall after a txclk pulse.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 hz100  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 state  input  4  lock FSM state code: 0-7 = LS0-LS7, 8 = INIT, 9 = OPEN, 10 = ALARM, 11-15 = unused.
REQ-006 txready  input  1  UART transmitter ready to accept a byte.
REQ-007 txdata  output  8  byte presented to the UART (registered).
REQ-008 txclk  output  1  one-cycle strobe that the UART uses to latch txdata (registered).
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 drop_cnt  output  4  saturating count of events lost to overwrite.

Function
REQ-011 Change detection: prev_state SHALL register state every cycle; an event SHALL fire in any cycle where state != prev_state and state <= 10.
REQ-012 A change to a code in 11-15 SHALL update prev_state and SHALL NOT produce an event.
REQ-013 Message table: every event SHALL map to exactly 4 ASCII bytes, transmitted in order:
  - LSn: 'L' (0x4C), '0'+n (0x30+n), 0x0D, 0x0A
  - INIT: 'I' 'N' 0x0D 0x0A
  - OPEN: 'O' 'K' 0x0D 0x0A
  - ALARM: 'A' '!' 0x0D 0x0A
REQ-014 Pending buffer: the block SHALL hold one pending slot (valid bit + 4-bit code); an event SHALL write the slot.
REQ-015 If the slot is already valid when an event writes it, the new code SHALL overwrite the old one and drop_cnt SHALL increment, saturating at 15.
REQ-016 The FSM SHALL have the states IDLE, SEND, PULSE, WAITLO.
REQ-017 IDLE: when the slot is valid, the FSM SHALL latch the code into the message register, set idx=0, clear the slot and go to SEND on the next cycle.
REQ-018 SEND: txdata SHALL equal byte[idx] of the message; when txready=1, the FSM SHALL go to PULSE.
REQ-019 PULSE: txclk SHALL be 1 for exactly one cycle, txdata SHALL be held, and the FSM SHALL go to WAITLO with the timeout counter cleared.
REQ-020 WAITLO: on txready=0 or timeout counter = TIMEOUT-1, the FSM SHALL go to IDLE if idx=3; otherwise it SHALL set idx=idx+1 and go to SEND.
REQ-021 Back-to-back: the first byte of a new message SHALL appear no earlier than 2 cycles after the last byte's exit from WAITLO (IDLE, then SEND).
REQ-022 Simultaneous event and IDLE consume: the slot SHALL end the cycle valid with the new code, the consumed code SHALL be transmitted, and drop_cnt SHALL be unchanged.
REQ-023 An event arriving during SEND, PULSE or WAITLO SHALL only affect the slot and SHALL NOT alter the message in flight.
REQ-024 txclk SHALL be 0 in every state except PULSE, and SHALL never be high for two consecutive cycles.
REQ-025 txdata SHALL be 0x00 in IDLE.

Reset
REQ-026 On reset the block SHALL set state register = IDLE, txdata = 0x00, txclk = 0, busy = 0, drop_cnt = 0, slot valid = 0, idx = 0.
REQ-027 On reset prev_state SHALL be loaded with 8 (INIT), so an input held at INIT after reset produces no event.
REQ-028 Reset asserted mid-message SHALL abort the message; the remaining bytes SHALL NOT be sent, and outputs SHALL reach reset values on the next edge.

Verification
REQ-029 Single event: state 8 -> 0, txready held 1 with a 1-cycle low after each txclk -> bytes 0x4C, 0x30, 0x0D, 0x0A, four txclk pulses, then busy=0.
REQ-030 Coalescing: state 0 -> 1 -> 2 on consecutive cycles while busy -> message "L0" completes, then "L2" is sent, "L1" is never sent, and drop_cnt=1.
REQ-031 Stuck ready: txready held 1 permanently, state 8 -> 9 -> each byte 'O','K',0x0D,0x0A advances after TIMEOUT cycles in WAITLO, and every txclk pulse is exactly 1 cycle wide.
REQ-032 Unused code: state 8 -> 12 -> 10 -> only "A!\r\n" is sent.
REQ-033 Saturation: 20 overwrites while busy -> drop_cnt=15 and it does not wrap.
REQ-034 Reset during PULSE of byte 2 of ALARM -> next cycle txclk=0, txdata=0x00, busy=0, and no further bytes are sent.
